// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: shared state/owner types, counter width and the arbitration rule
// used by mem_port_arbiter and its latency counter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // A simultaneous request goes to DM unless DM had the previous grant.
  function automatic arb_owner_t pick_owner(
    input logic       if_req,
    input logic       dm_req,
    input arb_owner_t last
  );
    if (if_req && dm_req) begin
      return (last == OWN_DM) ? OWN_IF : OWN_DM;
    end else if (dm_req) begin
      return OWN_DM;
    end else begin
      return OWN_IF;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_lat_counter.sv
`default_nettype none
// arb_lat_counter: loadable down-counter with a zero flag that paces each
// memory access of mem_port_arbiter.
module arb_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one single-port memory between the fetch and data requesters.
// Optional perf counters (perf_conflicts_o / perf_wait_o) when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_all_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_conflicts_o,
  output logic [15:0]       perf_wait_o
`endif
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;

  logic grant;
  logic finish;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  arb_lat_counter u_lat_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req_i || dm_req_i) state_d = BUSY;
      BUSY:    if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant    = 1'b0;
    finish   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    mem_en_o = 1'b0;
    mem_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        grant    = if_req_i | dm_req_i;
        cnt_load = grant;
      end
      BUSY: begin
        mem_en_o = 1'b1;
        mem_we_o = we_q;
        cnt_dec  = ~cnt_zero;
        finish   = cnt_zero;
      end
      default: ;
    endcase
  end

  // Access context is latched at grant; the requester may change its inputs afterwards.
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if (grant) begin
      owner_d = pick_owner(if_req_i, dm_req_i, last_q);
      last_d  = owner_d;
      if (owner_d == OWN_DM) begin
        addr_d  = dm_addr_i;
        we_d    = dm_we_i;
        wdata_d = dm_wdata_i;
      end else begin
        addr_d  = if_addr_i;
        we_d    = 1'b0;
      end
    end
    if (finish) begin
      if (owner_q == OWN_IF) begin
        if_ack_d   = 1'b1;
        if_rdata_d = mem_rdata_i;
      end else begin
        dm_ack_d = 1'b1;
        if (!we_q) dm_rdata_d = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_all_o = dm_req_i & ~dm_ack_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflicts_q, perf_conflicts_d;
  logic [15:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_conflicts_d = perf_conflicts_q;
    perf_wait_d      = perf_wait_q;
    if ((state_q == IDLE) && if_req_i && dm_req_i && (perf_conflicts_q != 16'hFFFF)) begin
      perf_conflicts_d = perf_conflicts_q + 16'd1;
    end
    if (stall_if_o && (perf_wait_q != 16'hFFFF)) begin
      perf_wait_d = perf_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflicts_q <= 16'd0;
      perf_wait_q      <= 16'd0;
    end else begin
      perf_conflicts_q <= perf_conflicts_d;
      perf_wait_q      <= perf_wait_d;
    end
  end

  assign perf_conflicts_o = perf_conflicts_q;
  assign perf_wait_o      = perf_wait_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (MEM_LAT = 2).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_all;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflicts, perf_wait;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_dm_rdata = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_rdata_o  (dm_rdata),
    .dm_ack_o    (dm_ack),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .stall_if_o  (stall_if),
    .stall_all_o (stall_all)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflicts_o (perf_conflicts),
    .perf_wait_o      (perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dm, output int cycles);
    cycles = 0;
    while (((dm ? dm_ack : if_ack) !== 1'b1) && (cycles < 40)) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %0b want 0", mem_en); end
    checks++; if ({if_ack, dm_ack, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_acks_we: got %03b want 000", {if_ack, dm_ack, mem_we}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, dm_rdata}); end
    rst_n = 1'b1;
    step();
    dm_req = 1; dm_addr = 32'h80; mem_rdata = 32'h0BAD_0BAD;
    step();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_pre_busy_en: got %0b want 1", mem_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_en, if_ack, dm_ack} !== 3'b000) begin errors++; $display("FAIL rst_abort_now: got %03b want 000", {mem_en, if_ack, dm_ack}); end
    dm_req = 0;
    step(); step();
    checks++; if (dm_ack !== 1'b0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_no_ack: got ack=%0b rdata=%h want 0/0", dm_ack, dm_rdata); end
    rst_n = 1'b1;
    step();
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_idle_en: got %0b want 0", mem_en); end
    if_req = 1; if_addr = 32'h10; mem_rdata = 32'h0000_0010;
    step();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL rst_idle_grant: got en=%0b addr=%h want 1/00000010", mem_en, mem_addr); end
    wait_ack(1'b0, cyc);
    checks++; if (cyc != 2 || if_rdata !== 32'h10) begin errors++; $display("FAIL rst_after_fetch: got cyc=%0d rdata=%h want 2/00000010", cyc, if_rdata); end
    exp_if_rdata = 32'h10;
    if_req = 0;
    step();
  endtask

  task automatic test_lone_fetch();
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h2002_0005;
    #1;
    checks++; if (mem_en !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_req: got en=%0b stall_if=%0b want 0/1", mem_en, stall_if); end
    step();
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_busy1: got en=%0b addr=%h we=%0b want 1/00000040/0", mem_en, mem_addr, mem_we); end
    step();
    checks++; if (mem_en !== 1'b1 || if_ack !== 1'b0) begin errors++; $display("FAIL fetch_busy2: got en=%0b ack=%0b want 1/0", mem_en, if_ack); end
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h2002_0005 || mem_en !== 1'b0 || stall_if !== 1'b0 || dm_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_ack: got ack=%0b rdata=%h en=%0b stall=%0b dm_ack=%0b want 1/20020005/0/0/0", if_ack, if_rdata, mem_en, stall_if, dm_ack); end
    exp_if_rdata = 32'h2002_0005;
    if_req = 0; mem_rdata = 32'hFFFF_FFFF;
    step();
    checks++; if (if_ack !== 1'b0 || if_rdata !== exp_if_rdata) begin errors++; $display("FAIL fetch_hold: got ack=%0b rdata=%h want 0/%h", if_ack, if_rdata, exp_if_rdata); end
  endtask

  task automatic test_contention();
    bit is_dm;
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h200; dm_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      is_dm = ((k % 2) == 0);
      mem_rdata = 32'hA000_0000 + 32'(k);
      step();
      checks++; if (mem_addr !== (is_dm ? 32'h300 : 32'h200)) begin errors++; $display("FAIL contend_grant%0d: got addr=%h want %h", k, mem_addr, is_dm ? 32'h300 : 32'h200); end
      checks++; if ({stall_if, stall_all} !== 2'b11) begin errors++; $display("FAIL contend_stall%0d: got %02b want 11", k, {stall_if, stall_all}); end
      step(); step();
      if (is_dm) exp_dm_rdata = mem_rdata; else exp_if_rdata = mem_rdata;
      checks++; if (if_ack !== !is_dm || dm_ack !== is_dm || if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
        errors++; $display("FAIL contend_ack%0d: got if_ack=%0b dm_ack=%0b if_rd=%h dm_rd=%h want %0b/%0b/%h/%h", k, if_ack, dm_ack, if_rdata, dm_rdata, !is_dm, is_dm, exp_if_rdata, exp_dm_rdata); end
      step();
    end
    if_req = 0; dm_req = 0;
    step();
  endtask

  task automatic test_store();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555;
    step();
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_busy1: got en=%0b we=%0b addr=%h wd=%h want 1/1/00000100/deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
    dm_wdata = 32'h0;
    step();
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_busy2: got we=%0b wd=%h want 1/deadbeef", mem_we, mem_wdata); end
    step();
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== exp_dm_rdata || mem_we !== 1'b0 || if_rdata !== exp_if_rdata) begin
      errors++; $display("FAIL store_ack: got ack=%0b rdata=%h we=%0b want 1/%h/0", dm_ack, dm_rdata, mem_we, exp_dm_rdata); end
    dm_req = 0; dm_we = 0;
    step();
    checks++; if (dm_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL store_done: got ack=%0b en=%0b want 0/0", dm_ack, mem_en); end
  endtask

  task automatic test_back_to_back();
    int en_cnt;
    int ack_cnt;
    int ack_at;
    en_cnt = 0; ack_cnt = 0; ack_at = -1;
    if_req = 1; if_addr = 32'h44; mem_rdata = 32'h1234_5678;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (ack_at >= 0 && i == ack_at + 1) if_req = 0;
      if (mem_en === 1'b1) en_cnt++;
      if (if_ack === 1'b1) begin ack_cnt++; ack_at = i; end
    end
    checks++; if (en_cnt != 2) begin errors++; $display("FAIL b2b_en_cycles: got %0d want 2", en_cnt); end
    checks++; if (ack_cnt != 1 || ack_at != 3) begin errors++; $display("FAIL b2b_ack: got count=%0d at=%0d want 1/3", ack_cnt, ack_at); end
    exp_if_rdata = 32'h1234_5678;
    checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL b2b_rdata: got %h want %h", if_rdata, exp_if_rdata); end
  endtask

  task automatic test_drop_mid();
    dm_req = 1; dm_we = 0; dm_addr = 32'h180; mem_rdata = 32'hCAFE_0001;
    step();
    dm_req = 0;
    step(); step();
    exp_dm_rdata = 32'hCAFE_0001;
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== exp_dm_rdata || stall_all !== 1'b0) begin
      errors++; $display("FAIL drop_mid_ack: got ack=%0b rdata=%h stall=%0b want 1/cafe0001/0", dm_ack, dm_rdata, stall_all); end
    step();
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    if_req = 1; dm_req = 1;
    repeat (12) step();
    if_req = 0; dm_req = 0;
    step();
    checks++; if (perf_conflicts !== 16'd3) begin errors++; $display("FAIL perf_conflicts3: got %0d want 3", perf_conflicts); end
    force dut.perf_conflicts_q = 16'hFFFE;
    #1 release dut.perf_conflicts_q;
    if_req = 1; dm_req = 1;
    repeat (8) step();
    if_req = 0; dm_req = 0;
    step();
    checks++; if (perf_conflicts !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %h want ffff", perf_conflicts); end
  endtask
`endif

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_store();
    test_back_to_back();
    test_drop_mid();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
